// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the gshare branch-predictor update path.
//   - 2-bit saturating counter encodings and the value the PHT is seeded with
//   - controller FSM state encoding
//   - in-flight queue entry layout {index, taken, pc bits}
// The entry fields are sized by BP_GSHARE_BITS_NUM, so the GSHARE_BITS_NUM
// parameter of bp_update_ctrl must be kept equal to it.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_GSHARE_BITS_NUM = 8;

    localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
    localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
    localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
    localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

    // Value written into every PHT entry during the init walk
    localparam logic [1:0] PHT_INIT_VALUE     = WEAKLY_TAKEN;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [BP_GSHARE_BITS_NUM-1:0] index;
        logic                          taken;
        logic [BP_GSHARE_BITS_NUM-1:0] pc_bits;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// ---------------------------------------------------------------------------
// bp_inflight_fifo
// Ordered queue of in-flight conditional-branch predictions.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push, push_entry    append an entry at the tail (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   clear               empty the queue; wins over push and pop
//   head_entry          oldest entry
//   occupancy           number of valid entries
//   full, empty         derived from occupancy
// Pointers wrap modulo DEPTH (power of two); full/empty come from the
// occupancy count rather than pointer comparison.
// ---------------------------------------------------------------------------
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  bp_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       clear,
    output bp_entry_t                  head_entry,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bp_entry_t              mem [DEPTH];
    logic [PTR_W-1:0]       head_ptr;
    logic [PTR_W-1:0]       tail_ptr;
    logic [CNT_W-1:0]       count;
    logic                   push_ok;
    logic                   pop_ok;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign occupancy  = count;
    assign head_entry = mem[head_ptr];
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;

    // Pointer and occupancy bookkeeping. A clear resets everything to the
    // empty state and discards any push or pop arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Entry storage holds only data; validity lives in the pointers, so no
    // reset is needed here.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[tail_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl
// Sequencing controller for the gshare predictor: walks the tables after
// reset, tracks in-flight predictions, and issues one PHT update plus one
// BHT shift per resolved branch with a registered mispredict pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   pred_*_i / pred_ready_o  prediction enqueue from fetch
//   resolve_*_i              resolution of the oldest in-flight branch
//   flush_i                  external pipeline flush (clears the queue)
//   pht_wr_* / bht_wr_*      table update strobes, one cycle after resolve
//   tbl_init_o/_index_o      init walk write (PHT<-WEAKLY_TAKEN, BHT<-0)
//   mispredict_o             one-cycle pulse on wrong direction
//   busy_o                   init walk in progress
//   underflow_o              sticky: resolve arrived with an empty queue
//   occupancy_o              valid queue entries
// Optional: define BP_UPDATE_CTRL_STATS_EN to add saturating counters
//   branch_cnt_o and mispredict_cnt_o.
// ---------------------------------------------------------------------------
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int GSHARE_BITS_NUM      = BP_GSHARE_BITS_NUM,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int QUEUE_DEPTH          = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pred_valid_i,
    input  logic [GSHARE_BITS_NUM-1:0]       pred_index_i,
    input  logic                             pred_taken_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  pred_pc_i,
    output logic                             pred_ready_o,
    input  logic                             resolve_valid_i,
    input  logic                             resolve_taken_i,
    input  logic                             flush_i,
    output logic                             pht_wr_en_o,
    output logic [GSHARE_BITS_NUM-1:0]       pht_wr_index_o,
    output logic                             pht_wr_taken_o,
    output logic                             bht_wr_en_o,
    output logic [GSHARE_BITS_NUM-1:0]       bht_wr_index_o,
    output logic                             bht_wr_bit_o,
    output logic                             tbl_init_o,
    output logic [GSHARE_BITS_NUM-1:0]       tbl_init_index_o,
    output logic                             mispredict_o,
    output logic                             busy_o,
    output logic                             underflow_o,
`ifdef BP_UPDATE_CTRL_STATS_EN
    output logic [31:0]                      branch_cnt_o,
    output logic [31:0]                      mispredict_cnt_o,
`endif
    output logic [$clog2(QUEUE_DEPTH):0]     occupancy_o
);

    localparam logic [GSHARE_BITS_NUM-1:0] LAST_INIT_INDEX = '1;

    bp_state_e                   state;
    bp_state_e                   next_state;
    logic                        tbl_init_next;
    logic [GSHARE_BITS_NUM-1:0]  init_index_next;

    bp_entry_t                   push_entry;
    bp_entry_t                   head_entry;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        in_run;
    logic                        do_push;
    logic                        do_resolve;
    logic                        do_mispredict;
    logic                        resolve_empty;
    logic                        queue_clear;
    logic                        unused_pc_bits;

    assign in_run        = (state == ST_RUN);
    assign busy_o        = (state == ST_INIT);
    assign pred_ready_o  = in_run && !fifo_full;
    assign do_push       = pred_valid_i && pred_ready_o;
    assign do_resolve    = in_run && resolve_valid_i && !fifo_empty;
    assign resolve_empty = in_run && resolve_valid_i && fifo_empty;
    assign do_mispredict = do_resolve && (resolve_taken_i != head_entry.taken);
    assign queue_clear   = do_mispredict || (in_run && flush_i);

    assign push_entry.index   = pred_index_i;
    assign push_entry.taken   = pred_taken_i;
    assign push_entry.pc_bits = pred_pc_i[GSHARE_BITS_NUM+1:2];

    // PC bits outside the BHT index field carry no information for this block
    assign unused_pc_bits = ^{pred_pc_i[OPTION_OPERAND_WIDTH-1:GSHARE_BITS_NUM+2], pred_pc_i[1:0]};

    bp_inflight_fifo #(
        .DEPTH      (QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (do_push),
        .push_entry (push_entry),
        .pop        (do_resolve),
        .clear      (queue_clear),
        .head_entry (head_entry),
        .occupancy  (occupancy_o),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // State register for the init/run controller. Reset parks it in INIT
    // with the walk not yet started, so tbl_init_o first rises one cycle
    // after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_INIT;
            tbl_init_o       <= 1'b0;
            tbl_init_index_o <= '0;
        end else begin
            state            <= next_state;
            tbl_init_o       <= tbl_init_next;
            tbl_init_index_o <= init_index_next;
        end
    end

    // Next-state logic for the table walk. The first INIT cycle arms the
    // walk at index 0; each further cycle advances one entry, and the cycle
    // after the last index has been written hands over to RUN.
    always_comb begin
        next_state      = state;
        tbl_init_next   = tbl_init_o;
        init_index_next = tbl_init_index_o;
        case (state)
            ST_INIT: begin
                if (!tbl_init_o) begin
                    tbl_init_next   = 1'b1;
                    init_index_next = '0;
                end else if (tbl_init_index_o == LAST_INIT_INDEX) begin
                    tbl_init_next   = 1'b0;
                    next_state      = ST_RUN;
                end else begin
                    init_index_next = tbl_init_index_o + GSHARE_BITS_NUM'(1);
                end
            end
            ST_RUN: begin
                next_state = ST_RUN;
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase
    end

    // Table write strobes and the mispredict pulse are registered one cycle
    // after the resolve. Data fields only move on a real resolve so they
    // keep the last update otherwise. Underflow stays set until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pht_wr_en_o    <= 1'b0;
            pht_wr_index_o <= '0;
            pht_wr_taken_o <= 1'b0;
            bht_wr_en_o    <= 1'b0;
            bht_wr_index_o <= '0;
            bht_wr_bit_o   <= 1'b0;
            mispredict_o   <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            pht_wr_en_o  <= do_resolve;
            bht_wr_en_o  <= do_resolve;
            mispredict_o <= do_mispredict;
            if (do_resolve) begin
                pht_wr_index_o <= head_entry.index;
                pht_wr_taken_o <= resolve_taken_i;
                bht_wr_index_o <= head_entry.pc_bits;
                bht_wr_bit_o   <= resolve_taken_i;
            end
            if (resolve_empty) begin
                underflow_o <= 1'b1;
            end
        end
    end

`ifdef BP_UPDATE_CTRL_STATS_EN
    // Saturating statistics. Both events require RUN, so the counters
    // naturally hold during the init walk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            if (do_resolve && (branch_cnt_o != '1)) begin
                branch_cnt_o <= branch_cnt_o + 32'd1;
            end
            if (do_mispredict && (mispredict_cnt_o != '1)) begin
                mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
